// File: rtl/alu_cmd_driver.sv
// Command FIFO plus a sequencer that feeds an external combinational ALU
// and returns its captured results over a valid/ready response channel.
module alu_cmd_driver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_x,
    input  logic [31:0] cmd_y,
    input  logic [3:0]  cmd_op,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_z,
    input  logic [2:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic [2:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] done_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [67:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;
    logic             capture_s;
    logic             accept_s;
    logic             reserved_s;
    logic [67:0]      head_s;

    // Op codes 4 and 11..15 have no ALU meaning; their results are forced to zero.
    function automatic logic is_reserved(input logic [3:0] op);
        return (op == 4'd4) || (op >= 4'd11);
    endfunction

    assign cmd_ready  = (count_r < DEPTH_C);
    assign push_s     = cmd_valid && cmd_ready;
    assign head_s     = mem_r[rd_ptr_r];
    assign reserved_s = is_reserved(alu_op);
    assign busy       = (count_r != {CNT_W{1'b0}}) || (state_r != IDLE);

    // Sequencer next-state and pop/capture/accept strobes.
    always_comb begin
        state_s   = state_r;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        accept_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    pop_s   = 1'b1;
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                capture_s = 1'b1;
                state_s   = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    accept_s = 1'b1;
                    if (count_r != {CNT_W{1'b0}}) begin
                        pop_s   = 1'b1;
                        state_s = EXEC;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_op, cmd_y, cmd_x};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // ALU operand registers and the response holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_x     <= 32'd0;
            alu_y     <= 32'd0;
            alu_op    <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_z     <= 32'd0;
            rsp_flags <= 3'd0;
            rsp_err   <= 1'b0;
            done_cnt  <= 16'd0;
        end else begin
            if (pop_s) begin
                alu_x  <= head_s[31:0];
                alu_y  <= head_s[63:32];
                alu_op <= head_s[67:64];
            end
            if (capture_s) begin
                rsp_valid <= 1'b1;
                rsp_err   <= reserved_s;
                rsp_z     <= reserved_s ? 32'd0 : alu_z;
                rsp_flags <= reserved_s ? 3'd0 : alu_flags;
            end else if (accept_s) begin
                rsp_valid <= 1'b0;
            end
            if (accept_s) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed and randomized bench for alu_cmd_driver with a stub ALU and an
// in-order response scoreboard.
module tb_alu_cmd_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_x;
    logic [31:0] cmd_y;
    logic [3:0]  cmd_op;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_op;
    logic [31:0] alu_z;
    logic [2:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_z;
    logic [2:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;
    logic [15:0] done_cnt;

    typedef struct {
        logic [31:0] z;
        logic [2:0]  f;
        logic        e;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [15:0] exp_done;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_op    (cmd_op),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_op    (alu_op),
        .alu_z     (alu_z),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    // Stub ALU; reserved ops return junk so the forced-zero capture is visible.
    function automatic logic [34:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] op);
        logic [31:0] z;
        logic        ovf;
        ovf = 1'b0;
        case (op)
            4'd0:  z = x & y;
            4'd1:  z = x | y;
            4'd2:  z = x ^ y;
            4'd3:  z = ~x;
            4'd5: begin
                z   = x + y;
                ovf = (x[31] == y[31]) && (z[31] != x[31]);
            end
            4'd6: begin
                z   = x - y;
                ovf = (x[31] != y[31]) && (z[31] != x[31]);
            end
            4'd7:  z = x << y[4:0];
            4'd8:  z = x >> y[4:0];
            4'd9:  z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd10: z = y;
            default: return {3'b111, 32'hDEADBEEF};
        endcase
        return {ovf, (x == y), (z == 32'd0), z};
    endfunction

    assign {alu_flags, alu_z} = alu_fn(alu_x, alu_y, alu_op);

    function automatic rsp_t ref_rsp(input logic [31:0] x, input logic [31:0] y,
                                     input logic [3:0] op);
        rsp_t r;
        if (op == 4'd4 || op >= 4'd11) begin
            r.z = 32'd0;
            r.f = 3'd0;
            r.e = 1'b1;
        end else begin
            {r.f, r.z} = alu_fn(x, y, op);
            r.e = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshakes that will complete on the coming edge.
    task automatic cycle();
        rsp_t e;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_z", rsp_z, e.z);
                chk("rsp_flags", {29'd0, rsp_flags}, {29'd0, e.f});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
                exp_done = exp_done + 16'd1;
            end
        end
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back(ref_rsp(cmd_x, cmd_y, cmd_op));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        cmd_x     = x;
        cmd_y     = y;
        cmd_op    = op;
        cmd_valid = 1'b1;
    endtask

    task automatic push_wait(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        set_cmd(x, y, op);
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) break;
            cycle();
        end
        chk("wait_rsp", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            cycle();
        end
        chk("drain_empty", exp_q.size(), 32'd0);
        cycle();
        chk("drain_done_cnt", {16'd0, done_cnt}, {16'd0, exp_done});
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] base;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = 32'd0;
        cmd_y     = 32'd0;
        cmd_op    = 4'd0;
        rsp_ready = 1'b0;
        exp_done  = 16'd0;
        #3;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
        chk("rst_alu_x", alu_x, 32'd0);
        chk("rst_alu_y", alu_y, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_rsp_z", rsp_z, 32'd0);
        chk("rst_rsp_flags", {29'd0, rsp_flags}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and basic add
        rsp_ready = 1'b1;
        set_cmd(32'd5, 32'd3, 4'b0101);
        cycle();
        cmd_valid = 1'b0;
        chk("lat_e0_valid", {31'd0, rsp_valid}, 32'd0);
        chk("lat_e0_busy", {31'd0, busy}, 32'd1);
        cycle();
        chk("lat_e1_valid", {31'd0, rsp_valid}, 32'd0);
        cycle();
        chk("lat_e2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("add_z", rsp_z, 32'd8);
        chk("add_flags", {29'd0, rsp_flags}, 32'd0);
        chk("add_err", {31'd0, rsp_err}, 32'd0);
        cycle();
        chk("add_done_cnt", {16'd0, done_cnt}, 32'd1);
        chk("add_valid_clr", {31'd0, rsp_valid}, 32'd0);

        // Overflow and equal/zero flags
        push_wait(32'h7FFFFFFF, 32'd1, 4'b0101);
        chk("ovf_z", rsp_z, 32'h80000000);
        chk("ovf_flags", {29'd0, rsp_flags}, 32'd4);
        cycle();
        push_wait(32'd9, 32'd9, 4'b0110);
        chk("eq_z", rsp_z, 32'd0);
        chk("eq_flags", {29'd0, rsp_flags}, 32'd3);
        cycle();

        // Reserved op codes
        push_wait(32'd17, 32'd17, 4'b0100);
        chk("res4_err", {31'd0, rsp_err}, 32'd1);
        chk("res4_z", rsp_z, 32'd0);
        chk("res4_flags", {29'd0, rsp_flags}, 32'd0);
        cycle();
        push_wait($urandom, $urandom, 4'b1111);
        chk("res15_err", {31'd0, rsp_err}, 32'd1);
        chk("res15_z", rsp_z, 32'd0);
        chk("res15_flags", {29'd0, rsp_flags}, 32'd0);
        cycle();
        drain();

        // Backpressure: one in flight plus a full FIFO
        base      = exp_done;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd($urandom, $urandom, 4'($urandom_range(0, 10)));
            cycle();
        end
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_accepted", exp_q.size(), 32'd5);
        for (int i = 0; i < 3; i++) begin
            set_cmd(32'hBAD0BAD0, 32'd1, 4'd5);
            chk("full_refuse", {31'd0, cmd_ready}, 32'd0);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_z", rsp_z, exp_q[0].z);
            cycle();
        end
        drain();
        chk("full_done_delta", {16'd0, exp_done - base}, 32'd5);

        // Push and pop on the same edge with two queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cmd($urandom, $urandom, 4'($urandom_range(0, 15)));
            cycle();
        end
        cmd_valid = 1'b0;
        chk("occ_before", {30'd0, dut.count_r}, 32'd2);
        chk("occ_resp", {31'd0, rsp_valid}, 32'd1);
        set_cmd($urandom, $urandom, 4'd2);
        rsp_ready = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        chk("occ_after", {30'd0, dut.count_r}, 32'd2);
        drain();

        // done_cnt wrap
        force dut.done_cnt = 16'hFFFF;
        #1;
        release dut.done_cnt;
        exp_done = 16'hFFFF;
        chk("wrap_preset", {16'd0, done_cnt}, 32'h0000FFFF);
        push_wait(32'd1, 32'd2, 4'd1);
        cycle();
        chk("wrap_zero", {16'd0, done_cnt}, 32'd0);

        // Asynchronous reset while holding a response with three queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd($urandom, $urandom, 4'd5);
            cycle();
        end
        cmd_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_done_cnt", {16'd0, done_cnt}, 32'd0);
        exp_q.delete();
        exp_done = 16'd0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            cycle();
        end
        chk("post_rst_done_cnt", {16'd0, done_cnt}, 32'd0);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_x     = $urandom;
            cmd_y     = ($urandom_range(0, 3) == 0) ? cmd_x : $urandom;
            cmd_op    = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
